bp_update_queue: RTL and testbench

Branch-resolution back end that feeds the branch predictor. It accepts up to two resolved control-flow instructions per cycle from the execute stage and compares each against its predicted next PC to raise a registered squash request. It buffers the resulting predictor updates in a small FIFO and drains up to two per cycle as `EX_BP_PACKET [1:0]` into `BP_top`'s `ex_bp_packet_in`. It is the producer end of the execute-to-predictor update interface.

---
 rtl/bp_update_queue_pkg.sv | 35 +++
 rtl/bp_upd_fifo.sv | 52 +++++
 rtl/bp_update_queue.sv | 154 +++++++++++++++
 tb/tb_bp_update_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_queue_pkg.sv
// Shared types for the execute-to-predictor update path: queue entry and predictor packet.
// Latency: n/a (types, constants and a pure next-PC helper only).
// Backpressure: n/a.
package bp_update_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Update packet consumed by BP_top's ex_bp_packet_in.
    typedef struct packed {
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] tg_pc;
        logic            br_en;
        logic            con_br_en;
        logic            con_br_taken;
    } EX_BP_PACKET;

    // One resolved branch waiting in the update queue. 'taken' is already
    // forced to 1 for unconditional jumps.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic            cond;
        logic            taken;
    } BP_UPD_ENTRY;

    // Architecturally correct next PC of a resolved control-flow instruction.
    function automatic logic [XLEN-1:0] actual_npc(input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] tgt,
                                                   input logic            taken);
        return taken ? tgt : pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-in/two-out circular buffer of BP_UPD_ENTRY with an occupancy count.
// Latency: a pushed entry is visible on head_dat from the next cycle.
// Backpressure: none internally; the caller must keep push_cnt within the free space and pop_cnt within count.
module bp_upd_fifo
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 push_cnt,
    input  BP_UPD_ENTRY [1:0]          push_dat,
    input  logic [1:0]                 pop_cnt,
    output BP_UPD_ENTRY [1:0]          head_dat,
    output logic [$clog2(DEPTH):0]     count
);

    // DEPTH must be a power of two so the pointers wrap by plain overflow.
    localparam int AW = $clog2(DEPTH);

    BP_UPD_ENTRY       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
        end
    end

    // Entry storage; push_dat[0] is always the older of the pushed entries.
    always_ff @(posedge clock) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_dat[0];
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= push_dat[1];
        end
    end

    assign head_dat[0] = mem[rd_ptr];
    assign head_dat[1] = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/bp_update_queue.sv
// Resolves up to two branches per cycle, raises a registered squash and queues predictor updates (optional stats: BP_UPD_STATS_EN).
// Latency: squash 1 cycle after the inputs; predictor update appears 2 cycles after the inputs (no bypass).
// Backpressure: ex_stall (combinational) when fewer than 2 entries are free; inputs are ignored while it is high.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             ex_br_valid,
    input  logic [1:0]             ex_br_cond,
    input  logic [1:0]             ex_br_taken,
    input  logic [1:0][XLEN-1:0]   ex_br_pc,
    input  logic [1:0][XLEN-1:0]   ex_br_tgt,
    input  logic [1:0][XLEN-1:0]   ex_pred_npc,
    output logic                   ex_stall,
    output logic                   squash_en,
    output logic [XLEN-1:0]        squash_pc,
    output EX_BP_PACKET [1:0]      ex_bp_packet_out
`ifdef BP_UPD_STATS_EN
    ,
    output logic [31:0]            stat_br_cnt,
    output logic [31:0]            stat_mispred_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            count;
    logic [1:0]             taken_eff;
    logic [1:0]             mispred;
    logic [1:0][XLEN-1:0]   npc;
    logic                   accept;
    logic                   keep1;
    logic                   squash_nxt;
    logic [XLEN-1:0]        squash_pc_nxt;
    logic [1:0]             push_cnt;
    logic [1:0]             pop_cnt;
    BP_UPD_ENTRY [1:0]      ent;
    BP_UPD_ENTRY [1:0]      push_dat;
    BP_UPD_ENTRY [1:0]      head_dat;

    // Stall on occupancy before this cycle's dequeue, so a slot freed by the
    // drain is never reused in the same cycle.
    assign ex_stall = (count > (AW+1)'(DEPTH - 2));

    // Resolve both slots, pick the squash source and pack enqueues without holes.
    always_comb begin
        taken_eff     = '0;
        mispred       = '0;
        npc           = '0;
        ent           = '0;
        accept        = 1'b0;
        keep1         = 1'b0;
        squash_nxt    = 1'b0;
        squash_pc_nxt = '0;
        push_cnt      = 2'd0;
        push_dat      = '0;
        pop_cnt       = 2'd0;

        for (int s = 0; s < 2; s++) begin
            taken_eff[s]  = ~ex_br_cond[s] | ex_br_taken[s];
            npc[s]        = actual_npc(ex_br_pc[s], ex_br_tgt[s], taken_eff[s]);
            mispred[s]    = ex_br_valid[s] & (ex_pred_npc[s] != npc[s]);
            ent[s].pc     = ex_br_pc[s];
            ent[s].tgt    = ex_br_tgt[s];
            ent[s].cond   = ex_br_cond[s];
            ent[s].taken  = taken_eff[s];
        end

        accept = ~ex_stall;
        // A slot-0 mispredict makes slot 1 wrong-path: drop it entirely.
        keep1  = ex_br_valid[1] & ~mispred[0];

        squash_nxt    = accept & (mispred[0] | (keep1 & mispred[1]));
        squash_pc_nxt = mispred[0] ? npc[0] : npc[1];

        if (accept) begin
            push_cnt = {1'b0, ex_br_valid[0]} + {1'b0, keep1};
        end
        push_dat[0] = ex_br_valid[0] ? ent[0] : ent[1];
        push_dat[1] = ent[1];

        pop_cnt = (count >= (AW+1)'(2)) ? 2'd2 : count[1:0];
    end

    bp_upd_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_cnt (push_cnt),
        .push_dat (push_dat),
        .pop_cnt  (pop_cnt),
        .head_dat (head_dat),
        .count    (count)
    );

    // Squash request: one-cycle pulse; the PC holds until the next squash.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            squash_en <= 1'b0;
            squash_pc <= '0;
        end else begin
            squash_en <= squash_nxt;
            if (squash_nxt) begin
                squash_pc <= squash_pc_nxt;
            end
        end
    end

    // Drain up to two entries per cycle; idle slots clear the enables but keep PC/tg_pc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_bp_packet_out <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (pop_cnt > 2'(s)) begin
                    ex_bp_packet_out[s].PC           <= head_dat[s].pc;
                    ex_bp_packet_out[s].tg_pc        <= head_dat[s].tgt;
                    ex_bp_packet_out[s].br_en        <= 1'b1;
                    ex_bp_packet_out[s].con_br_en    <= head_dat[s].cond;
                    ex_bp_packet_out[s].con_br_taken <= head_dat[s].taken;
                end else begin
                    ex_bp_packet_out[s].br_en        <= 1'b0;
                    ex_bp_packet_out[s].con_br_en    <= 1'b0;
                    ex_bp_packet_out[s].con_br_taken <= 1'b0;
                end
            end
        end
    end

`ifdef BP_UPD_STATS_EN
    // Saturating counters of accepted branches and squash-causing mispredicts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_br_cnt      <= '0;
            stat_mispred_cnt <= '0;
        end else begin
            if (stat_br_cnt > (STAT_MAX - 32'(push_cnt))) begin
                stat_br_cnt <= STAT_MAX;
            end else begin
                stat_br_cnt <= stat_br_cnt + 32'(push_cnt);
            end
            if (squash_nxt && (stat_mispred_cnt != STAT_MAX)) begin
                stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed self-checking bench for bp_update_queue (DEPTH = 8).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: ex_stall checked directly; the full boundary is reached by forcing the queue count.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    logic                   clock;
    logic                   reset;
    logic [1:0]             ex_br_valid;
    logic [1:0]             ex_br_cond;
    logic [1:0]             ex_br_taken;
    logic [1:0][XLEN-1:0]   ex_br_pc;
    logic [1:0][XLEN-1:0]   ex_br_tgt;
    logic [1:0][XLEN-1:0]   ex_pred_npc;
    logic                   ex_stall;
    logic                   squash_en;
    logic [XLEN-1:0]        squash_pc;
    EX_BP_PACKET [1:0]      pkt;
`ifdef BP_UPD_STATS_EN
    logic [31:0]            stat_br_cnt;
    logic [31:0]            stat_mispred_cnt;
`endif

    int errors = 0;
    int checks = 0;

    bp_update_queue #(.DEPTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .ex_br_valid      (ex_br_valid),
        .ex_br_cond       (ex_br_cond),
        .ex_br_taken      (ex_br_taken),
        .ex_br_pc         (ex_br_pc),
        .ex_br_tgt        (ex_br_tgt),
        .ex_pred_npc      (ex_pred_npc),
        .ex_stall         (ex_stall),
        .squash_en        (squash_en),
        .squash_pc        (squash_pc),
        .ex_bp_packet_out (pkt)
`ifdef BP_UPD_STATS_EN
        ,
        .stat_br_cnt      (stat_br_cnt),
        .stat_mispred_cnt (stat_mispred_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] c, input logic [1:0] t,
                         input logic [31:0] p0, input logic [31:0] g0, input logic [31:0] n0,
                         input logic [31:0] p1, input logic [31:0] g1, input logic [31:0] n1);
        ex_br_valid    = v;
        ex_br_cond     = c;
        ex_br_taken    = t;
        ex_br_pc[0]    = p0;
        ex_br_tgt[0]   = g0;
        ex_pred_npc[0] = n0;
        ex_br_pc[1]    = p1;
        ex_br_tgt[1]   = g1;
        ex_pred_npc[1] = n1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic EX_BP_PACKET mk(input logic [31:0] pc, input logic [31:0] tgt,
                                       input logic c, input logic t);
        EX_BP_PACKET p;
        p.PC           = pc;
        p.tg_pc        = tgt;
        p.br_en        = 1'b1;
        p.con_br_en    = c;
        p.con_br_taken = t;
        return p;
    endfunction

    // Stream pattern: slot-valid bits per cycle; odd cycles misalign the pointers.
    logic [1:0] pat [6] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01};

    initial begin
        int          prev_n;
        logic [31:0] prev_pc [2];
        int          cur_n;
        logic [31:0] cur_pc [2];
        logic [31:0] base;

        reset = 1'b0;
        idle();
        #12;
        reset = 1'b1;
        #1;

        // Reset state
        check("rst_stall",  160'(ex_stall),  160'(0));
        check("rst_squash", 160'(squash_en), 160'(0));
        check("rst_sqpc",   160'(squash_pc), 160'(0));
        check("rst_pkt",    160'(pkt),       160'(0));

        // T1: correctly predicted taken branch in slot 0 only
        drive(2'b01, 2'b01, 2'b01, 32'h10, 32'h40, 32'h40, 0, 0, 0);
        tick();
        check("t1_nosquash", 160'(squash_en), 160'(0));
        idle();
        tick();
        check("t1_out0", 160'(pkt[0]), 160'(mk(32'h10, 32'h40, 1'b1, 1'b1)));
        check("t1_out1_en", 160'(pkt[1].br_en), 160'(0));
        tick();
        check("t1_empty_en", 160'(pkt[0].br_en), 160'(0));
        check("t1_empty_pc_held", 160'(pkt[0].PC), 160'(32'h10));

        // T2: slot 0 not-taken mispredict; slot 1 is wrong-path
        drive(2'b11, 2'b11, 2'b10, 32'h20, 32'h99, 32'h80, 32'h24, 32'h200, 32'h200);
        tick();
        check("t2_squash_en", 160'(squash_en), 160'(1));
        check("t2_squash_pc", 160'(squash_pc), 160'(32'h24));
        idle();
        tick();
        check("t2_squash_pulse", 160'(squash_en), 160'(0));
        check("t2_out0", 160'(pkt[0]), 160'(mk(32'h20, 32'h99, 1'b1, 1'b0)));
        check("t2_out1_en", 160'(pkt[1].br_en), 160'(0));

        // T3: slot 0 correct; slot 1 JAL mispredicted
        drive(2'b11, 2'b01, 2'b01, 32'h28, 32'h50, 32'h50, 32'h30, 32'h100, 32'h34);
        tick();
        check("t3_squash_en", 160'(squash_en), 160'(1));
        check("t3_squash_pc", 160'(squash_pc), 160'(32'h100));
        idle();
        tick();
        check("t3_out0", 160'(pkt[0]), 160'(mk(32'h28, 32'h50, 1'b1, 1'b1)));
        check("t3_out1", 160'(pkt[1]), 160'(mk(32'h30, 32'h100, 1'b0, 1'b1)));
        check("t3_sqpc_held", 160'(squash_pc), 160'(32'h100));
`ifdef BP_UPD_STATS_EN
        check("stat_br", 160'(stat_br_cnt), 160'(4));
        check("stat_mis", 160'(stat_mispred_cnt), 160'(2));
`endif

        // T4: continuous stream past the pointer wrap, FIFO order preserved
        prev_n = 0;
        prev_pc[0] = 0;
        prev_pc[1] = 0;
        for (int i = 0; i < 6; i++) begin
            base = 32'h1000 + 32'(i) * 32'h10;
            drive(pat[i], 2'b11, 2'b00, base, base + 32'h800, base + 32'h4,
                  base + 32'h8, base + 32'h808, base + 32'hC);
            cur_n = 0;
            cur_pc[0] = 0;
            cur_pc[1] = 0;
            if (pat[i][0]) begin
                cur_pc[cur_n] = base;
                cur_n++;
            end
            if (pat[i][1]) begin
                cur_pc[cur_n] = base + 32'h8;
                cur_n++;
            end
            check("t4_stall", 160'(ex_stall), 160'(0));
            tick();
            check("t4_nosquash", 160'(squash_en), 160'(0));
            if (i > 0) begin
                check("t4_en0", 160'(pkt[0].br_en), 160'(prev_n >= 1));
                check("t4_en1", 160'(pkt[1].br_en), 160'(prev_n == 2));
                if (prev_n >= 1) check("t4_pc0", 160'(pkt[0].PC), 160'(prev_pc[0]));
                if (prev_n == 2) check("t4_pc1", 160'(pkt[1].PC), 160'(prev_pc[1]));
            end
            prev_n = cur_n;
            prev_pc[0] = cur_pc[0];
            prev_pc[1] = cur_pc[1];
        end
        idle();
        tick();
        check("t4_last_en0", 160'(pkt[0].br_en), 160'(1));
        check("t4_last_pc0", 160'(pkt[0].PC), 160'(prev_pc[0]));
        check("t4_last_tg0", 160'(pkt[0].tg_pc), 160'(prev_pc[0] + 32'h800));
        check("t4_last_en1", 160'(pkt[1].br_en), 160'(0));

        // T5: full boundary; stall at count 7 blocks enqueue and squash
        force dut.u_fifo.count = 4'd6;
        #1;
        check("t5_stall_c6", 160'(ex_stall), 160'(0));
        force dut.u_fifo.count = 4'd7;
        #1;
        check("t5_stall_c7", 160'(ex_stall), 160'(1));
        drive(2'b01, 2'b01, 2'b01, 32'h500, 32'h600, 32'h504, 0, 0, 0);
        tick();
        check("t5_no_squash", 160'(squash_en), 160'(0));
        idle();
        release dut.u_fifo.count;
        reset = 1'b0;
        #1;
        check("t5_rst_stall", 160'(ex_stall), 160'(0));
        #1;
        reset = 1'b1;
        tick();
        check("t5_after_en0", 160'(pkt[0].br_en), 160'(0));
        check("t5_after_en1", 160'(pkt[1].br_en), 160'(0));

        // T6: asynchronous reset with entries in flight and a squash pending
        drive(2'b11, 2'b11, 2'b00, 32'h700, 32'h900, 32'h704, 32'h708, 32'h900, 32'h70C);
        tick();
        drive(2'b11, 2'b11, 2'b01, 32'h710, 32'h900, 32'h714, 32'h718, 32'h900, 32'h71C);
        tick();
        check("t6_pre_squash", 160'(squash_en), 160'(1));
        check("t6_pre_out0", 160'(pkt[0]), 160'(mk(32'h700, 32'h900, 1'b1, 1'b0)));
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_pkt", 160'(pkt), 160'(0));
        check("t6_rst_squash", 160'(squash_en), 160'(0));
        check("t6_rst_sqpc", 160'(squash_pc), 160'(0));
        check("t6_rst_stall", 160'(ex_stall), 160'(0));
        #1;
        reset = 1'b1;
        tick();
        check("t6_stale0", 160'(pkt[0].br_en), 160'(0));
        check("t6_stale1", 160'(pkt[1].br_en), 160'(0));
        tick();
        check("t6_stale0b", 160'(pkt[0].br_en), 160'(0));
        check("t6_nosquash", 160'(squash_en), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
